dram_model: RTL and testbench

DRAM_MODEL -- requirements
Module: dram_model

---
 rtl/dram_pkg.sv | 30 +++
 rtl/dram_rd_pipe.sv | 32 +++
 rtl/dram_model.sv | 79 +++++++
 tb/tb_dram_model.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared geometry, latency and command decode for the behavioural DRAM model.
// Word address is {row, col}; the four byte lanes are stored in separate arrays.
package dram_pkg;
  localparam int ROW_W     = 11;
  localparam int COL_W     = 10;
  localparam int ADDR_W    = ROW_W + COL_W;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int CAS_LAT   = 5;
  localparam int NUM_LANES = 4;
  localparam int DATA_W    = 8 * NUM_LANES;

  typedef enum logic [2:0] {NOP, ACT, PRE, RD, WR, ILLEGAL} cmd_e;
  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  // Any WEn bit low turns ACT into PRE and RD into WR.
  function automatic cmd_e decode_cmd(input logic csn, input logic rasn,
                                      input logic casn, input logic [NUM_LANES-1:0] wen);
    cmd_e c;
    c = NOP;
    if (!csn) begin
      case ({rasn, casn})
        2'b00:   c = ILLEGAL;
        2'b01:   c = (&wen) ? ACT : PRE;
        2'b10:   c = (&wen) ? RD  : WR;
        default: c = NOP;
      endcase
    end
    return c;
  endfunction
endpackage

// File: rtl/dram_rd_pipe.sv
// Fixed CAS-latency read pipeline: CAS_LAT data stages plus a holding output
// register, so Q keeps its last value between read bursts.
import dram_pkg::*;

module dram_rd_pipe (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data
);
  logic [CAS_LAT:0]                vld_pipe;
  logic [CAS_LAT-1:0][DATA_W-1:0]  dat_pipe;
  logic [DATA_W-1:0]               q_hold;

  // Stage 0 loads on the command edge; the output lands CAS_LAT edges later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
      q_hold   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[CAS_LAT-1:0], in_vld};
      dat_pipe <= {dat_pipe[CAS_LAT-2:0], in_data};
      if (vld_pipe[CAS_LAT-1]) q_hold <= dat_pipe[CAS_LAT-1];
    end
  end

  assign out_vld  = vld_pipe[CAS_LAT];
  assign out_data = q_hold;
endmodule

// File: rtl/dram_model.sv
// Single-bank DRAM model: command decoder, open-row state, byte-lane storage,
// and a fixed-latency read path.
import dram_pkg::*;

module dram_model (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 CSn,
  input  logic                 RASn,
  input  logic                 CASn,
  input  logic [NUM_LANES-1:0] WEn,
  input  logic [ROW_W-1:0]     A,
  input  logic [DATA_W-1:0]    D,
  output logic [DATA_W-1:0]    Q,
  output logic                 VALID
);
  // Not reset: contents survive RST and may be loaded hierarchically.
  logic [7:0] Memory_byte0 [DEPTH];
  logic [7:0] Memory_byte1 [DEPTH];
  logic [7:0] Memory_byte2 [DEPTH];
  logic [7:0] Memory_byte3 [DEPTH];

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  cmd_e               cmd;
  logic               rd_fire, wr_fire;
  logic [ADDR_W-1:0]  waddr;
  logic [DATA_W-1:0]  rd_word;

  assign cmd   = decode_cmd(CSn, RASn, CASn, WEn);
  assign waddr = {row_q, A[COL_W-1:0]};

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    rd_fire = 1'b0;
    wr_fire = 1'b0;
    if (!RST) begin
      case (cmd)
        ACT: if (state_q == ST_IDLE) begin
          state_d = ST_ACTIVE;
          row_d   = A;
        end
        PRE:     state_d = ST_IDLE;
        RD:      rd_fire = (state_q == ST_ACTIVE);
        WR:      wr_fire = (state_q == ST_ACTIVE);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CK) if (wr_fire && !WEn[0]) Memory_byte0[waddr] <= D[7:0];
  always_ff @(posedge CK) if (wr_fire && !WEn[1]) Memory_byte1[waddr] <= D[15:8];
  always_ff @(posedge CK) if (wr_fire && !WEn[2]) Memory_byte2[waddr] <= D[23:16];
  always_ff @(posedge CK) if (wr_fire && !WEn[3]) Memory_byte3[waddr] <= D[31:24];

  // Sampled on the command edge, so a later write cannot disturb it.
  assign rd_word = {Memory_byte3[waddr], Memory_byte2[waddr],
                    Memory_byte1[waddr], Memory_byte0[waddr]};

  dram_rd_pipe u_rd_pipe (
    .clk      (CK),
    .rst      (RST),
    .in_vld   (rd_fire),
    .in_data  (rd_word),
    .out_vld  (VALID),
    .out_data (Q)
  );
endmodule

// File: tb/tb_dram_model.sv
// Directed plus randomized checks of dram_model against a word-level reference.
module tb_dram_model;
  logic        CK = 1'b0;
  logic        RST, CSn, RASn, CASn;
  logic [3:0]  WEn;
  logic [10:0] A;
  logic [31:0] D, Q;
  logic        VALID;

  always #5 CK = ~CK;

  dram_model dut (
    .CK(CK), .RST(RST), .CSn(CSn), .RASn(RASn), .CASn(CASn),
    .WEn(WEn), .A(A), .D(D), .Q(Q), .VALID(VALID)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit [31:0] mem_m [int];
  bit        open_m;
  bit [10:0] row_m;
  typedef struct { int due; bit [31:0] data; } rd_t;
  rd_t       pend[$];
  bit [31:0] last_q;
  int        used[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit [31:0] mget(input int a);
    return mem_m.exists(a) ? mem_m[a] : 32'h0;
  endfunction

  task automatic poke(input int a, input bit [31:0] v);
    dut.Memory_byte0[a] = v[7:0];
    dut.Memory_byte1[a] = v[15:8];
    dut.Memory_byte2[a] = v[23:16];
    dut.Memory_byte3[a] = v[31:24];
    mem_m[a] = v;
    used.push_back(a);
  endtask

  task automatic mem_chk(input int a);
    chk("mem", {dut.Memory_byte3[a], dut.Memory_byte2[a], dut.Memory_byte1[a], dut.Memory_byte0[a]}, mget(a));
  endtask

  // Reference behaviour of one rising edge, in terms of commands and words.
  task automatic model_edge();
    int a;
    bit [31:0] w;
    if (RST) begin
      pend.delete(); last_q = 0; open_m = 0; row_m = 0;
      return;
    end
    if (CSn) return;
    a = {row_m, A[9:0]};
    if (!RASn && CASn) begin
      if (WEn == 4'hF) begin
        if (!open_m) begin open_m = 1; row_m = A; end
      end else open_m = 0;
    end else if (RASn && !CASn && open_m) begin
      if (WEn == 4'hF) pend.push_back('{cyc + 5, mget(a)});
      else begin
        w = mget(a);
        for (int i = 0; i < 4; i++) if (!WEn[i]) w[8*i +: 8] = D[8*i +: 8];
        mem_m[a] = w;
      end
    end
  endtask

  task automatic check_out();
    bit        ev;
    bit [31:0] eq;
    ev = 0; eq = last_q;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev = 1; eq = pend[0].data; last_q = eq;
      void'(pend.pop_front());
    end
    chk("valid", {31'b0, VALID}, {31'b0, ev});
    chk("q", Q, eq);
  endtask

  task automatic step(input bit csn, input bit rasn, input bit casn,
                      input bit [3:0] wen, input bit [10:0] a, input bit [31:0] d);
    @(negedge CK);
    CSn = csn; RASn = rasn; CASn = casn; WEn = wen; A = a; D = d;
    @(posedge CK);
    cyc++;
    model_edge();
    #1 check_out();
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, 4'hF, 11'h0, 32'h0);
  endtask
  task automatic act(input bit [10:0] r);      step(1'b0, 1'b0, 1'b1, 4'hF, r, 32'h0); endtask
  task automatic pre();                         step(1'b0, 1'b0, 1'b1, 4'h0, 11'h0, 32'h0); endtask
  task automatic rd(input bit [10:0] c);       step(1'b0, 1'b1, 1'b0, 4'hF, c, 32'h0); endtask
  task automatic wr(input bit [10:0] c, input bit [31:0] d, input bit [3:0] w);
    step(1'b0, 1'b1, 1'b0, w, c, d);
  endtask

  initial begin
    bit [10:0] rows[3];
    bit [10:0] cols[9];
    bit [3:0]  w;
    bit [10:0] c;
    int        k;
    rows = '{11'h100, 11'h101, 11'h7FF};
    cols = '{11'h0, 11'h1, 11'h2, 11'h3, 11'h4, 11'h5, 11'h6, 11'h7, 11'h3FF};

    RST = 1'b1; CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF; A = '0; D = '0;
    #1;
    chk("rst_valid", {31'b0, VALID}, 32'h0);
    chk("rst_q", Q, 32'h0);
    nop(2);
    @(negedge CK) RST = 1'b0;

    // Basic read, five-edge latency, single-cycle VALID
    poke(32'h40000, 32'hDEADBEEF);
    act(11'h100);
    rd(11'h000);
    nop(7);

    // Byte-lane write over existing data
    poke(32'h40001, 32'hAABBCCDD);
    wr(11'h001, 32'h11223344, 4'b1010);
    rd(11'h001);
    nop(7);
    mem_chk(32'h40001);

    // Back-to-back reads
    poke(32'h40000, 32'd1); poke(32'h40001, 32'd2); poke(32'h40002, 32'd3);
    rd(11'h000); rd(11'h001); rd(11'h002);
    nop(7);

    // Read data is frozen at its command edge; column ignores A[10]
    poke(32'h40005, 32'h55667788);
    rd(11'h405);
    wr(11'h005, 32'hFFFFFFFF, 4'h0);
    nop(7);
    mem_chk(32'h40005);

    // PRE lets reads in flight finish
    rd(11'h002);
    pre();
    nop(6);

    // Idle: reads and writes do nothing, including after PRE in IDLE
    rd(11'h000);
    wr(11'h001, 32'h0BADF00D, 4'h0);
    pre();
    rd(11'h001);
    step(1'b0, 1'b0, 1'b0, 4'hF, 11'h100, 32'h0);
    nop(10);
    mem_chk(32'h40001);

    // Reset in the middle of a read
    act(11'h100);
    rd(11'h000);
    nop(2);
    #2 RST = 1'b1;
    #1;
    pend.delete(); last_q = 0; open_m = 0; row_m = 0;
    chk("rst_mid_valid", {31'b0, VALID}, 32'h0);
    chk("rst_mid_q", Q, 32'h0);
    act(11'h100);
    wr(11'h000, 32'h12345678, 4'h0);
    rd(11'h000);
    @(negedge CK) RST = 1'b0;
    nop(8);
    mem_chk(32'h40000);
    mem_chk(32'h40002);

    // Chip deselected: no command takes effect
    act(11'h100);
    step(1'b1, 1'b1, 1'b0, 4'h0, 11'h003, 32'hCAFEF00D);
    step(1'b1, 1'b1, 1'b0, 4'hF, 11'h001, 32'h0);
    step(1'b1, 1'b0, 1'b1, 4'h0, 11'h000, 32'h0);
    nop(7);
    mem_chk(32'h40003);
    rd(11'h002);
    nop(6);

    // Randomized traffic over three rows, including the top word address
    pre();
    foreach (rows[r]) foreach (cols[j]) poke({rows[r], cols[j][9:0]}, $urandom());
    for (int n = 0; n < 600; n++) begin
      k = $urandom_range(0, 9);
      w = 4'($urandom_range(0, 14));
      c = cols[$urandom_range(0, 8)] | (11'($urandom_range(0, 1)) << 10);
      case (k)
        0: step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w, c, $urandom());
        1: act(rows[$urandom_range(0, 2)]);
        2: step(1'b0, 1'b0, 1'b1, w, c, 32'h0);
        3, 4, 5: rd(c);
        6, 7: wr(c, $urandom(), w);
        8: step(1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)), c, $urandom());
        default: step(1'b0, 1'b1, 1'b1, w, c, $urandom());
      endcase
    end
    nop(8);
    foreach (used[i]) mem_chk(used[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
